// File: rtl/joybus_device.sv
// joybus_device: JOYBUS controller endpoint that decodes console commands 0x00/0x01/0xFF and returns status or poll data.
// Define JB_PAK_DETECT_EN to add the pak_present input that selects the third status byte.
module joybus_device #(
   parameter int CLKS_PER_US = 50
) (
   input  logic        clk,
   input  logic        rst_n,
   inout  wire         JB,
   input  logic [31:0] cntlr_data,
`ifdef JB_PAK_DETECT_EN
   input  logic        pak_present,
`endif
   output logic        cmd_vld,
   output logic [7:0]  cmd,
   output logic        busy,
   output logic        err
);
   localparam logic [11:0] C1 = 12'(CLKS_PER_US);
   localparam logic [11:0] C2 = 12'(2 * CLKS_PER_US);
   localparam logic [11:0] C3 = 12'(3 * CLKS_PER_US);
   localparam logic [11:0] C4 = 12'(4 * CLKS_PER_US);
   localparam logic [11:0] C8 = 12'(8 * CLKS_PER_US);
   typedef enum logic [2:0] {IDLE, RX_BIT, RX_STOP, TURN, TX_BIT, TX_STOP, DRAIN} state_t;
   state_t      st_q, st_d;
   logic        s1_q, s2_q, ln_q, w0_q, w1_q, hi_q;
   logic [11:0] t_q, t_d;
   logic [5:0]  n_q, n_d;
   logic [7:0]  sh_q, sh_d, cmd_q, cmd_d;
   logic [31:0] tx_q, tx_d;
   logic        long_q, long_d, vld_q, vld_d, err_q, err_d;
   logic        drv, fall, rise;
   logic [7:0]  status2;
`ifdef JB_PAK_DETECT_EN
   assign status2 = pak_present ? 8'h01 : 8'h02;
`else
   assign status2 = 8'h02;
`endif
   assign fall    = ln_q & ~s2_q;
   assign rise    = ~ln_q & s2_q;
   assign busy    = st_q != IDLE;
   assign cmd     = cmd_q;
   assign cmd_vld = vld_q;
   assign err     = err_q;
   // Reset gates the driver directly so the line is freed without a clock edge.
   assign JB      = (drv && rst_n) ? 1'b0 : 1'bz;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1_q   <= 1'b1;
         s2_q   <= 1'b1;
         ln_q   <= 1'b1;
         w0_q   <= 1'b0;
         w1_q   <= 1'b0;
         hi_q   <= 1'b0;
         st_q   <= IDLE;
         t_q    <= '0;
         n_q    <= '0;
         sh_q   <= '0;
         tx_q   <= '0;
         long_q <= 1'b0;
         cmd_q  <= '0;
         vld_q  <= 1'b0;
         err_q  <= 1'b0;
      end else begin
         s1_q   <= JB;
         s2_q   <= s1_q;
         ln_q   <= s2_q;
         w0_q   <= 1'b1;
         w1_q   <= w0_q;
         hi_q   <= hi_q | (w1_q & s2_q);
         st_q   <= st_d;
         t_q    <= t_d;
         n_q    <= n_d;
         sh_q   <= sh_d;
         tx_q   <= tx_d;
         long_q <= long_d;
         cmd_q  <= cmd_d;
         vld_q  <= vld_d;
         err_q  <= err_d;
      end
   always_comb begin
      st_d   = st_q;
      t_d    = (t_q == 12'hFFF) ? t_q : t_q + 12'd1;
      n_d    = n_q;
      sh_d   = sh_q;
      tx_d   = tx_q;
      long_d = long_q;
      cmd_d  = cmd_q;
      vld_d  = 1'b0;
      err_d  = 1'b0;
      drv    = 1'b0;
      // Receive-side timers measure from the most recent edge; transmit ignores our own edges.
      if ((st_q == IDLE || st_q == RX_BIT || st_q == RX_STOP || st_q == DRAIN) && (fall || rise))
         t_d = '0;
      case (st_q)
         IDLE:
            if (fall && hi_q) begin
               n_d  = '0;
               st_d = RX_BIT;
            end
         RX_BIT:
            if ((!s2_q && !fall && t_q >= C4) || (s2_q && !rise && t_q >= C8)) begin
               err_d = 1'b1;
               st_d  = DRAIN;
               t_d   = '0;
            end else if (n_q == 6'd8) begin
               if (s2_q) st_d = RX_STOP;
            end else if (rise && t_q + 12'd1 < C2) begin
               sh_d = {sh_q[6:0], 1'b1};
               n_d  = n_q + 6'd1;
            end else if (!s2_q && t_q + 12'd1 == C2) begin
               sh_d = {sh_q[6:0], 1'b0};
               n_d  = n_q + 6'd1;
            end
         RX_STOP:
            if ((!s2_q && !fall && t_q >= C3) || (s2_q && !rise && t_q >= C8) ||
                (rise && (t_q + 12'd1 < C1 || !(sh_q == 8'h00 || sh_q == 8'h01 || sh_q == 8'hFF)))) begin
               err_d = 1'b1;
               st_d  = DRAIN;
               t_d   = '0;
            end else if (rise) begin
               vld_d  = 1'b1;
               cmd_d  = sh_q;
               long_d = sh_q == 8'h01;
               tx_d   = (sh_q == 8'h01) ? cntlr_data : {8'h05, 8'h00, status2, 8'h00};
               st_d   = TURN;
            end
         TURN:
            if (t_q == C2 - 12'd1) begin
               t_d  = '0;
               n_d  = '0;
               st_d = TX_BIT;
            end
         TX_BIT: begin
            drv = t_q < (tx_q[31] ? C1 : C3);
            if (t_q == C4 - 12'd1) begin
               t_d  = '0;
               tx_d = {tx_q[30:0], 1'b0};
               n_d  = n_q + 6'd1;
               if (n_q == (long_q ? 6'd31 : 6'd23)) st_d = TX_STOP;
            end
         end
         TX_STOP: begin
            drv = t_q < C2;
            if (t_q == C2) st_d = IDLE;
         end
         DRAIN:
            if (s2_q && !rise && t_q >= C8 - 12'd1) st_d = IDLE;
         default: st_d = IDLE;
      endcase
   end
endmodule

// File: tb/tb_joybus_device.sv
// tb_joybus_device: console-side bench that sends command frames and decodes the device's pulse-width reply.
module tb_joybus_device;
   localparam int C = 50;
   logic        clk = 1'b0, rst_n = 1'b0, con_low = 1'b0;
   logic [31:0] cntlr_data = '0;
`ifdef JB_PAK_DETECT_EN
   logic        pak_present = 1'b0;
`endif
   wire         JB;
   logic        cmd_vld, busy, err;
   logic [7:0]  cmd;
   int          checks = 0, failures = 0, n_vld = 0, n_err = 0, n_drv = 0;
   assign JB = con_low ? 1'b0 : 1'bz;
   pullup (JB);
   always #5 clk = ~clk;
   joybus_device #(.CLKS_PER_US(C)) dut (
      .clk(clk), .rst_n(rst_n), .JB(JB), .cntlr_data(cntlr_data),
`ifdef JB_PAK_DETECT_EN
      .pak_present(pak_present),
`endif
      .cmd_vld(cmd_vld), .cmd(cmd), .busy(busy), .err(err));
   always @(posedge clk) begin
      if (cmd_vld) n_vld <= n_vld + 1;
      if (err) n_err <= n_err + 1;
      if (JB === 1'b0 && !con_low) n_drv <= n_drv + 1;
   end
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask
   task automatic send_bit(input logic b);
      con_low = 1'b1;
      cyc(b ? C : 3 * C);
      con_low = 1'b0;
      cyc(b ? 3 * C : C);
   endtask
   task automatic send_byte(input logic [7:0] v);
      for (int i = 7; i >= 0; i--) send_bit(v[i]);
   endtask
   task automatic send_stop();
      con_low = 1'b1;
      cyc(2 * C);
      con_low = 1'b0;
   endtask
   function automatic logic [7:0] status2();
`ifdef JB_PAK_DETECT_EN
      return pak_present ? 8'h01 : 8'h02;
`else
      return 8'h02;
`endif
   endfunction
   // Decodes the reply by pulse widths: 1 us low = 1, 3 us low = 0, 2 us low = stop.
   task automatic rx_reply(input logic [31:0] exp, input int nb);
      int w, h;
      h = 0;
      do begin cyc(1); h++; end while (JB !== 1'b0 && h < 1000);
      chk("turnaround_in_range", 32'(h >= 2 * C && h <= 2 * C + 8), 32'd1);
      if (h >= 1000) return;
      for (int i = 0; i < nb; i++) begin
         w = 0;
         while (JB === 1'b0 && w < 1000) begin cyc(1); w++; end
         chk($sformatf("bit%0d_low", i), w, exp[31-i] ? C : 3 * C);
         if (i == 4) cntlr_data = $urandom;
         h = 0;
         while (JB !== 1'b0 && h < 1000) begin cyc(1); h++; end
         chk($sformatf("bit%0d_high", i), h, exp[31-i] ? 3 * C : C);
         if (w >= 1000 || h >= 1000) return;
      end
      w = 0;
      while (JB === 1'b0 && w < 1000) begin cyc(1); w++; end
      chk("stop_low", w, 2 * C);
      chk("busy_at_release", busy, 1);
      cyc(1);
      chk("busy_after_release", busy, 0);
   endtask
   task automatic txn(input logic [7:0] c, input logic [31:0] d);
      int v0, e0, d0;
      logic [31:0] exp;
      cntlr_data = d;
      v0 = n_vld;
      e0 = n_err;
      d0 = n_drv;
      exp = (c == 8'h01) ? d : {8'h05, 8'h00, status2(), 8'h00};
      send_byte(c);
      send_stop();
      if (c == 8'h00 || c == 8'h01 || c == 8'hFF) begin
         rx_reply(exp, (c == 8'h01) ? 32 : 24);
         chk("cmd_vld_once", n_vld, v0 + 1);
         chk("cmd_value", cmd, c);
         chk("no_err", n_err, e0);
      end else begin
         cyc(8 * C - 5);
         chk("drain_busy", busy, 1);
         cyc(13);
         chk("drain_idle", busy, 0);
         chk("unsup_err", n_err, e0 + 1);
         chk("unsup_no_vld", n_vld, v0);
         chk("unsup_no_drive", n_drv, d0);
      end
      cyc(20);
   endtask
   initial begin
      int v0, e0, d0;
      logic [7:0] sup [3];
      sup = '{8'h00, 8'h01, 8'hFF};
      cyc(3);
      chk("rst_jb", JB, 1);
      chk("rst_busy", busy, 0);
      chk("rst_err", err, 0);
      chk("rst_vld", cmd_vld, 0);
      chk("rst_cmd", cmd, 0);
      rst_n = 1'b1;
      cyc(10);
      txn(8'h01, 32'h8000_0001);
      txn(8'h00, $urandom);
      txn(8'hFF, $urandom);
      txn(8'h02, $urandom);
      for (int k = 0; k < 5; k++) begin
`ifdef JB_PAK_DETECT_EN
         pak_present = 1'($urandom);
`endif
         txn(sup[$urandom_range(0, 2)], $urandom);
      end
      for (int k = 0; k < 2; k++) txn(8'($urandom_range(2, 254)), $urandom);
      // Line stuck low during command bit 3.
      v0 = n_vld;
      e0 = n_err;
      d0 = n_drv;
      send_bit(1'b0);
      send_bit(1'b1);
      send_bit(1'b0);
      con_low = 1'b1;
      cyc(300);
      chk("stuck_err", n_err, e0 + 1);
      con_low = 1'b0;
      cyc(8 * C + 10);
      chk("stuck_idle", busy, 0);
      chk("stuck_no_vld", n_vld, v0);
      chk("stuck_no_drive", n_drv, d0);
      cyc(20);
      // Reset while the device is driving a 0 bit of the second reply byte.
      cntlr_data = 32'h5A00_C3A5;
      send_byte(8'h01);
      send_stop();
      d0 = 0;
      do begin cyc(1); d0++; end while (JB !== 1'b0 && d0 < 1000);
      cyc(32 * C + 10);
      chk("pre_reset_driving", JB, 0);
      rst_n = 1'b0;
      #1;
      chk("async_release", JB, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_cmd", cmd, 0);
      chk("mid_rst_vld", cmd_vld, 0);
      chk("mid_rst_err", err, 0);
      cyc(3);
      rst_n = 1'b1;
      cyc(8 * 4 * C);
      txn(8'hFF, $urandom);
      // Line already low when reset is released must be ignored.
      con_low = 1'b1;
      rst_n = 1'b0;
      cyc(3);
      e0 = n_err;
      rst_n = 1'b1;
      cyc(300);
      chk("low_after_rst_busy", busy, 0);
      con_low = 1'b0;
      cyc(20);
      chk("low_after_rst_idle", busy, 0);
      chk("low_after_rst_err", n_err, e0);
      txn(8'h01, $urandom);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
